// File: rtl/mult_rr_scheduler.sv
// Round-robin front end for one shared single-cycle signed multiplier.
// Issues registered operands, tags each op with its requester id, and drains the pipe when precision changes.
module mult_rr_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_PRECISION = 16,
  parameter int ID_W          = 2
) (
  input  logic                               clk_gate,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*MAX_PRECISION-1:0]   req_jia,
  input  logic [NUM_REQ*MAX_PRECISION-1:0]   req_yi,
  input  logic [NUM_REQ*6-1:0]               req_prec,
  output logic                               m_en,
  output logic                               m_valid,
  output logic [MAX_PRECISION-1:0]           m_jia,
  output logic [MAX_PRECISION-1:0]           m_yi,
  output logic [5:0]                         m_precision,
  input  logic [2*MAX_PRECISION-1:0]         m_zi,
  input  logic                               m_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [2*MAX_PRECISION-1:0]         rsp_zi,
  output logic                               err_spurious,
  output logic [31:0]                        op_count
);

  typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_e;

  state_e                   state_q, state_d;
  logic [ID_W-1:0]          rr_ptr_q;
  logic [5:0]               cur_prec_q, cur_prec_d;
  logic [2:1]               vld_pipe_q;
  logic [2:1][ID_W-1:0]     id_pipe_q;
  logic [MAX_PRECISION-1:0] m_jia_q, m_yi_q;
  logic [5:0]               m_prec_q;
  logic                     err_q;
  logic [31:0]              op_count_q;

  logic                     win_found;
  logic [ID_W-1:0]          win_id;
  logic [5:0]               win_prec;
  logic                     prec_ok, xfer, pipe_empty, rsp_fire;

  // Scan from the highest offset down so the offset closest to rr_ptr wins.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign win_prec   = req_prec[int'(win_id)*6 +: 6];
  assign prec_ok    = (win_prec == cur_prec_q);
  assign xfer       = win_found && prec_ok && (state_q != SWITCH);
  assign pipe_empty = ~|vld_pipe_q;
  assign rsp_fire   = m_ready && vld_pipe_q[2];

  always_comb begin
    state_d    = state_q;
    cur_prec_d = cur_prec_q;
    case (state_q)
      IDLE, RUN: begin
        if (win_found)       state_d = prec_ok ? RUN : SWITCH;
        else if (pipe_empty) state_d = IDLE;
        else                 state_d = RUN;
      end
      SWITCH: begin
        if (pipe_empty) begin
          if (win_found) begin
            cur_prec_d = win_prec;
            state_d    = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_gate or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cur_prec_q <= 6'd16;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      m_jia_q    <= '0;
      m_yi_q     <= '0;
      m_prec_q   <= '0;
      err_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_prec_q <= cur_prec_d;
      vld_pipe_q <= {vld_pipe_q[1], xfer};
      id_pipe_q  <= {id_pipe_q[1], win_id};
      if (xfer) begin
        rr_ptr_q <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        m_jia_q  <= req_jia[int'(win_id)*MAX_PRECISION +: MAX_PRECISION];
        m_yi_q   <= req_yi[int'(win_id)*MAX_PRECISION +: MAX_PRECISION];
        m_prec_q <= win_prec;
      end
      if (m_ready && !vld_pipe_q[2]) err_q <= 1'b1;
      if (rsp_fire && op_count_q != 32'hFFFF_FFFF) op_count_q <= op_count_q + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign req_ready[i] = xfer && (win_id == ID_W'(i));
    assign rsp_valid[i] = rsp_fire && (id_pipe_q[2] == ID_W'(i));
  end

  assign m_valid      = vld_pipe_q[1];
  assign m_en         = (|req_valid) || (|vld_pipe_q);
  assign m_jia        = m_jia_q;
  assign m_yi         = m_yi_q;
  assign m_precision  = m_prec_q;
  assign rsp_zi       = rsp_fire ? m_zi : '0;
  assign err_spurious = err_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Random + directed bench for mult_rr_scheduler with a behavioural multiplier stub and
// a scoreboard fed at grant time and drained by a negedge monitor.
module tb_mult_rr_scheduler;
  localparam int N = 4;
  localparam int P = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [N-1:0]          req_valid, req_ready, rsp_valid;
  logic [N-1:0][P-1:0]   jia, yi;
  logic [N-1:0][5:0]     prec;
  logic                  m_en, m_valid, m_ready, err_spurious;
  logic [P-1:0]          m_jia, m_yi;
  logic [5:0]            m_precision;
  logic [2*P-1:0]        m_zi, rsp_zi;
  logic [31:0]           op_count;

  mult_rr_scheduler #(.NUM_REQ(N), .MAX_PRECISION(P), .ID_W(2)) dut (
    .clk_gate(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_jia(jia), .req_yi(yi), .req_prec(prec), .m_en(m_en), .m_valid(m_valid),
    .m_jia(m_jia), .m_yi(m_yi), .m_precision(m_precision), .m_zi(m_zi),
    .m_ready(m_ready), .rsp_valid(rsp_valid), .rsp_zi(rsp_zi),
    .err_spurious(err_spurious), .op_count(op_count)
  );

  function automatic logic [31:0] prod32(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return sa * sb;
  endfunction

  // Shared multiplier stand-in: registered product and ready, one cycle after m_valid.
  logic        mrdy_q, spur;
  logic [31:0] mzi_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mrdy_q <= 1'b0;
      mzi_q  <= '0;
    end else begin
      mrdy_q <= m_valid;
      mzi_q  <= prod32(m_jia, m_yi);
    end
  end
  assign m_ready = mrdy_q | spur;
  assign m_zi    = mzi_q;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [31:0] zi; int cyc; } exp_t;
  exp_t        sbq[$];
  int          mptr, exp_cnt, gnt_last, last_xfer_cyc, run1, run1_max;
  int          gcnt[N];
  logic        exp_mv, stable, saw_big;
  logic [15:0] exp_j, exp_y;
  logic [5:0]  exp_p;
  logic [31:0] last_rsp_zi;

  // Monitor: responses vs. scoreboard, issue vs. last grant, grants vs. round-robin model.
  always @(negedge clk) begin
    int w, gid;
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      mptr = 0; exp_cnt = 0; exp_mv = 1'b0; gnt_last = -1;
    end else begin
      chk("op_count", op_count, exp_cnt);
      if (rsp_valid != '0) begin
        if (sbq.size() == 0) chk("rsp_unexpected", rsp_valid, '0);
        else begin
          e = sbq.pop_front();
          chk("rsp_id", rsp_valid, 1 << e.id);
          chk("rsp_zi", rsp_zi, e.zi);
          chk("rsp_latency", cyc - e.cyc, 2);
        end
        exp_cnt++;
        last_rsp_zi = rsp_zi;
        if (rsp_valid == 4'b0010 && rsp_zi == 32'd1073741824) saw_big = 1'b1;
      end else if (sbq.size() > 0 && cyc - sbq[0].cyc >= 2) begin
        e = sbq.pop_front();
        chk("rsp_missing", rsp_valid, 1 << e.id);
      end
      if (rsp_valid == 4'b0010) begin
        run1++;
        if (run1 > run1_max) run1_max = run1;
      end else run1 = 0;

      chk("m_valid", m_valid, exp_mv);
      if (exp_mv) begin
        chk("m_jia", m_jia, exp_j);
        chk("m_yi", m_yi, exp_y);
        chk("m_precision", m_precision, exp_p);
      end

      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
      gid = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
      if ($countones(req_ready) > 1) chk("ready_onehot", req_ready, 1 << gid);
      if (gid >= 0) begin
        chk("grant_id", gid, w);
        sbq.push_back('{id: gid, zi: prod32(jia[gid], yi[gid]), cyc: cyc});
        mptr = (gid + 1) % N;
        exp_mv = 1'b1; exp_j = jia[gid]; exp_y = yi[gid]; exp_p = prec[gid];
        gcnt[gid]++;
        last_xfer_cyc = cyc;
      end else begin
        exp_mv = 1'b0;
        if (stable && w >= 0) chk("grant_missing", req_ready, 1 << w);
      end
      gnt_last = gid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refresh();
    if (gnt_last >= 0) begin
      jia[gnt_last] = 16'($urandom);
      yi[gnt_last]  = 16'($urandom);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_m_valid"}, m_valid, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_req_ready"}, req_ready, 0);
    chk({nm, "_op_count"}, op_count, 0);
    chk({nm, "_err"}, err_spurious, 0);
    chk({nm, "_m_ops"}, {m_jia, m_yi, m_precision}, 0);
    chk({nm, "_m_en"}, m_en, 0);
  endtask

  logic [15:0] t3_tbl [8];
  int t0, g0, waited;

  initial begin
    t3_tbl = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0003, 16'hFF00, 16'h1234, 16'h8001};
    stable = 1'b0; saw_big = 1'b0; run1 = 0; run1_max = 0; spur = 1'b0;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    req_valid = '0; prec = {N{6'd16}};
    for (int i = 0; i < N; i++) begin jia[i] = 16'($urandom); yi[i] = 16'($urandom); end
    rst_n = 1'b1; #1 rst_n = 1'b0;
    tick(); tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: single op 3 * -5
    stable = 1'b1;
    jia[0] = 16'd3; yi[0] = 16'hFFFB; req_valid = 4'b0001;
    #1 chk("t1_m_en", m_en, 1);
    tick();
    chk("t1_grant", gnt_last, 0);
    req_valid = '0;
    tick(); tick();
    chk("t1_op_count", op_count, 1);
    chk("t1_zi", last_rsp_zi, 32'hFFFF_FFF1);

    // 2: all requesters valid, then random valid patterns
    g0 = gcnt[0];
    req_valid = 4'b1111;
    for (int c = 0; c < 40; c++) begin tick(); refresh(); end
    chk("t2_fair", gcnt[0] - g0, 10);
    for (int c = 0; c < 60; c++) begin tick(); refresh(); req_valid = 4'($urandom); end
    req_valid = '0;
    repeat (4) tick();

    // 3: requester 1 back-to-back
    req_valid = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      jia[1] = t3_tbl[k]; yi[1] = t3_tbl[(k == 0) ? 0 : 7 - k];
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    chk("t3_run", run1_max >= 8, 1);
    chk("t3_big", saw_big, 1);

    // 4: precision change drains the pipe before the first 8-bit grant
    req_valid = 4'b0001;
    repeat (5) begin tick(); refresh(); end
    t0 = last_xfer_cyc;
    stable = 1'b0;
    prec[2] = 6'd8; req_valid = 4'b0100;
    waited = 0;
    while (gnt_last != 2 && waited < 20) begin tick(); waited++; end
    chk("t4_granted", gnt_last, 2);
    chk("t4_switch_lat", last_xfer_cyc - t0, 4);
    chk("t4_m_precision", m_precision, 8);
    stable = 1'b1;
    repeat (3) begin tick(); refresh(); end
    req_valid = '0;
    repeat (4) tick();

    // 5: spurious m_ready with nothing in flight
    chk("t5_err_before", err_spurious, 0);
    spur = 1'b1; tick(); spur = 1'b0; tick();
    chk("t5_err_set", err_spurious, 1);
    repeat (3) tick();
    chk("t5_err_sticky", err_spurious, 1);

    // 6: reset right after a transfer discards it
    req_valid = 4'b0100;
    tick();
    chk("t6_grant", gnt_last, 2);
    req_valid = '0; rst_n = 1'b0;
    #1 chk_zero("t6_reset");
    tick();
    rst_n = 1'b1;
    prec = {N{6'd16}}; req_valid = 4'b1111;
    tick();
    chk("t6_restart_ptr", gnt_last, 0);
    repeat (8) begin tick(); refresh(); end
    req_valid = '0;
    repeat (4) tick();
    chk("final_queue_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
